// File: rtl/rc4_ctrl.sv
// rc4_ctrl: RC4 key-schedule and keystream controller driving an external
// three-port S-box RAM. Keystream bytes leave on a valid/ready stream.
// Build option: define RC4_DROP256_EN to discard the first 256 keystream
// bytes (RC4-drop[256]) before anything is presented on the stream.
module rc4_ctrl #(
    parameter int KEY_LEN = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    output logic [4:0] o_key_idx,
    input  logic [7:0] i_key_byte,
    output logic       o_s_init,
    output logic [7:0] o_raddr_1,
    input  logic [7:0] i_rdata_1,
    output logic       o_wen_2,
    output logic [7:0] o_waddr_2,
    output logic [7:0] o_wdata_2,
    output logic       o_wen_3,
    output logic [7:0] o_addr_3,
    output logic [7:0] o_wdata_3,
    input  logic [7:0] i_rdata_3,
    output logic [7:0] o_ks_data,
    output logic       o_ks_valid,
    input  logic       i_ks_ready,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_KSA_A,
        S_KSA_B,
        S_PRGA_A,
        S_PRGA_B,
        S_PRGA_C,
        S_OUT
    } state_t;

    localparam logic [4:0] K_LAST = 5'(KEY_LEN - 1);

    state_t     r_state;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_tmp;
    logic [7:0] r_ja;
    logic [7:0] r_t;
    logic [4:0] r_k;
    logic [7:0] r_ks_data;
    logic       r_ks_valid;
`ifdef RC4_DROP256_EN
    logic [7:0] r_drop;
    logic       r_dropping;
`endif

    logic [7:0] w_in;
    logic [7:0] w_jn;
    logic [7:0] w_raddr_1;
    logic [7:0] w_addr_3;
    logic       w_wen_2;
    logic [7:0] w_waddr_2;
    logic [7:0] w_wdata_2;
    logic       w_wen_3;
    logic [7:0] w_wdata_3;

    assign w_in = r_i + 8'd1;

    // S-box port decode: the first half of a swap reads both entries and writes
    // S[j] into slot i through port 2; the second half writes the latched S[i]
    // into slot j through port 3, so i == j naturally leaves S unchanged.
    always_comb begin
        w_jn      = r_j;
        w_raddr_1 = 8'd0;
        w_addr_3  = 8'd0;
        w_wen_2   = 1'b0;
        w_waddr_2 = 8'd0;
        w_wdata_2 = 8'd0;
        w_wen_3   = 1'b0;
        w_wdata_3 = 8'd0;
        case (r_state)
            S_KSA_A: begin
                w_raddr_1 = r_i;
                w_jn      = r_j + i_rdata_1 + i_key_byte;
                w_addr_3  = w_jn;
                w_wen_2   = 1'b1;
                w_waddr_2 = r_i;
                w_wdata_2 = i_rdata_3;
            end
            S_KSA_B, S_PRGA_B: begin
                w_addr_3  = r_ja;
                w_wen_3   = 1'b1;
                w_wdata_3 = r_tmp;
            end
            S_PRGA_A: begin
                w_raddr_1 = w_in;
                w_jn      = r_j + i_rdata_1;
                w_addr_3  = w_jn;
                w_wen_2   = 1'b1;
                w_waddr_2 = w_in;
                w_wdata_2 = i_rdata_3;
            end
            S_PRGA_C: begin
                w_raddr_1 = r_t;
            end
            default: begin
                w_jn = r_j;
            end
        endcase
    end

    // Controller state machine, index registers and the registered keystream output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_k        <= 5'd0;
            r_tmp      <= 8'd0;
            r_ja       <= 8'd0;
            r_t        <= 8'd0;
            r_ks_data  <= 8'd0;
            r_ks_valid <= 1'b0;
`ifdef RC4_DROP256_EN
            r_drop     <= 8'd0;
            r_dropping <= 1'b0;
`endif
        end else if (r_state != S_IDLE && i_stop) begin
            r_state    <= S_IDLE;
            r_ks_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_INIT;
                        r_i     <= 8'd0;
                        r_j     <= 8'd0;
                        r_k     <= 5'd0;
                    end
                end
                S_INIT: begin
                    r_state <= S_KSA_A;
                end
                S_KSA_A: begin
                    r_tmp   <= i_rdata_1;
                    r_ja    <= w_jn;
                    r_j     <= w_jn;
                    r_state <= S_KSA_B;
                end
                S_KSA_B: begin
                    r_i <= w_in;
                    r_k <= (r_k == K_LAST) ? 5'd0 : r_k + 5'd1;
                    if (r_i == 8'd255) begin
                        r_j     <= 8'd0;
                        r_state <= S_PRGA_A;
`ifdef RC4_DROP256_EN
                        r_drop     <= 8'd0;
                        r_dropping <= 1'b1;
`endif
                    end else begin
                        r_state <= S_KSA_A;
                    end
                end
                S_PRGA_A: begin
                    r_i     <= w_in;
                    r_j     <= w_jn;
                    r_ja    <= w_jn;
                    r_tmp   <= i_rdata_1;
                    r_t     <= i_rdata_1 + i_rdata_3;
                    r_state <= S_PRGA_B;
                end
                S_PRGA_B: begin
`ifdef RC4_DROP256_EN
                    if (r_dropping) begin
                        r_drop  <= r_drop + 8'd1;
                        r_state <= S_PRGA_A;
                        if (r_drop == 8'd255) begin
                            r_dropping <= 1'b0;
                        end
                    end else begin
                        r_state <= S_PRGA_C;
                    end
`else
                    r_state <= S_PRGA_C;
`endif
                end
                S_PRGA_C: begin
                    r_ks_data  <= i_rdata_1;
                    r_ks_valid <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (i_ks_ready) begin
                        r_ks_valid <= 1'b0;
                        r_state    <= S_PRGA_A;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_key_idx  = r_k;
    assign o_s_init   = (r_state == S_INIT);
    assign o_raddr_1  = w_raddr_1;
    assign o_wen_2    = w_wen_2;
    assign o_waddr_2  = w_waddr_2;
    assign o_wdata_2  = w_wdata_2;
    assign o_wen_3    = w_wen_3;
    assign o_addr_3   = w_addr_3;
    assign o_wdata_3  = w_wdata_3;
    assign o_ks_data  = r_ks_data;
    assign o_ks_valid = r_ks_valid;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_rc4_ctrl.sv
// tb_rc4_ctrl: three rc4_ctrl lanes (KEY_LEN 3/4/6 with keys "Key", "Wiki",
// "Secret"), each with its own behavioural S-box RAM. Lane 0 also carries
// the back-pressure, stop and reset sequences. When RC4_DROP256_EN is
// defined the expected stream comes from a software RC4 reference instead.
module tb_rc4_ctrl;

    localparam int NL = 3;
`ifdef RC4_DROP256_EN
    localparam int FIRST_LAT = 1029;
`else
    localparam int FIRST_LAT = 517;
`endif

    typedef struct {
        int         lane;
        int         nBytes;
        logic [7:0] expBytes [10];
    } vecT;

    logic       clk = 1'b0;
    logic       rst;
    logic       start   [NL];
    logic       stop    [NL];
    logic       ksReady [NL];
    logic [4:0] keyIdx  [NL];
    logic [7:0] keyByte [NL];
    logic       sInit   [NL];
    logic [7:0] raddr1  [NL];
    logic [7:0] rdata1  [NL];
    logic       wen2    [NL];
    logic [7:0] waddr2  [NL];
    logic [7:0] wdata2  [NL];
    logic       wen3    [NL];
    logic [7:0] addr3   [NL];
    logic [7:0] wdata3  [NL];
    logic [7:0] rdata3  [NL];
    logic [7:0] ksData  [NL];
    logic       ksValid [NL];
    logic       busy    [NL];

    logic [7:0] keyMem    [NL][32];
    logic [7:0] expStream [NL][10];
    vecT        vecs      [3];

    int tests = 0;
    int fails = 0;
    int bothWen = 0;
    int wenWhenQuiet = 0;
    int sInitCnt [NL];

    always #5 clk = ~clk;

    // One DUT plus one behavioural S-box RAM per lane; port 2 wins on a shared address.
    for (genvar g = 0; g < NL; g++) begin : gLane
        logic [7:0] mem [256];

        rc4_ctrl #(.KEY_LEN((g == 0) ? 3 : ((g == 1) ? 4 : 6))) dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_start    (start[g]),
            .i_stop     (stop[g]),
            .o_key_idx  (keyIdx[g]),
            .i_key_byte (keyByte[g]),
            .o_s_init   (sInit[g]),
            .o_raddr_1  (raddr1[g]),
            .i_rdata_1  (rdata1[g]),
            .o_wen_2    (wen2[g]),
            .o_waddr_2  (waddr2[g]),
            .o_wdata_2  (wdata2[g]),
            .o_wen_3    (wen3[g]),
            .o_addr_3   (addr3[g]),
            .o_wdata_3  (wdata3[g]),
            .i_rdata_3  (rdata3[g]),
            .o_ks_data  (ksData[g]),
            .o_ks_valid (ksValid[g]),
            .i_ks_ready (ksReady[g]),
            .o_busy     (busy[g])
        );

        assign rdata1[g]  = mem[raddr1[g]];
        assign rdata3[g]  = mem[addr3[g]];
        assign keyByte[g] = keyMem[g][keyIdx[g]];

        // RAM model: s_init restores the identity permutation, otherwise apply writes.
        always @(posedge clk) begin
            if (sInit[g]) begin
                for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
            end else begin
                if (wen3[g]) mem[addr3[g]] <= wdata3[g];
                if (wen2[g]) mem[waddr2[g]] <= wdata2[g];
            end
        end
    end

    // Bus monitor: write-port overlap, writes while idle/init/output, and s_init pulse count.
    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) begin
            if (wen2[g] && wen3[g]) bothWen++;
            if ((!busy[g] || sInit[g] || ksValid[g]) && (wen2[g] || wen3[g])) wenWhenQuiet++;
            if (sInit[g]) sInitCnt[g]++;
        end
    end

    // Safety net so a hung DUT still ends the run.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int lane);
        @(negedge clk);
        start[lane] = 1'b1;
        @(posedge clk);
        #1;
        start[lane] = 1'b0;
    endtask

    task automatic applyStop(input int lane);
        @(negedge clk);
        stop[lane] = 1'b1;
        @(posedge clk);
        #1;
        stop[lane] = 1'b0;
    endtask

    // Waits for ks_valid as seen by a consumer at a rising edge; waited counts edges.
    task automatic getByte(input int lane, input int budget, output logic [7:0] b,
                           output int waited, output bit ok);
        logic       v;
        logic [7:0] d;
        int         cnt;
        cnt = 0;
        ok  = 1'b0;
        b   = 8'd0;
        while (cnt < budget && !ok) begin
            @(negedge clk);
            v = ksValid[lane];
            d = ksData[lane];
            @(posedge clk);
            cnt++;
            if (v) begin
                ok = 1'b1;
                b  = d;
            end
        end
        waited = cnt;
    endtask

    task automatic checkStream(input int lane, input int nBytes, input string tag);
        logic [7:0] b;
        int         w;
        bit         ok;
        for (int n = 0; n < nBytes; n++) begin
            getByte(lane, (n == 0) ? 1500 : 20, b, w, ok);
            if (!ok) begin
                checkOutput($sformatf("%s timeout byte%0d", tag, n), 0, 1);
                break;
            end
            checkOutput($sformatf("%s byte%0d", tag, n), b, expStream[lane][n]);
            if (n == 0) checkOutput($sformatf("%s first latency", tag), w, FIRST_LAT);
            if (n == 1) checkOutput($sformatf("%s byte period", tag), w, 4);
        end
    endtask

    function automatic int keyLenOf(input int lane);
        return (lane == 0) ? 3 : ((lane == 1) ? 4 : 6);
    endfunction

`ifdef RC4_DROP256_EN
    // Plain software RC4, skipping the first 'skip' keystream bytes.
    task automatic buildRef(input int lane, input int skip);
        int s [256];
        int i;
        int j;
        int x;
        int klen;
        klen = keyLenOf(lane);
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + int'(keyMem[lane][a % klen])) % 256;
            x = s[a]; s[a] = s[j]; s[j] = x;
        end
        i = 0;
        j = 0;
        for (int n = 0; n < skip + 10; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            x = s[i]; s[i] = s[j]; s[j] = x;
            if (n >= skip) expStream[lane][n - skip] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask
`endif

    initial begin
        logic [7:0] b;
        int         w1;
        int         w2;
        int         base;
        int         stableCnt;
        int         cnt;
        bit         ok;
        bit         found;

        vecs[0].lane = 0; vecs[0].nBytes = 10;
        vecs[0].expBytes = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        vecs[1].lane = 1; vecs[1].nBytes = 6;
        vecs[1].expBytes = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].lane = 2; vecs[2].nBytes = 8;
        vecs[2].expBytes = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59, 8'h00, 8'h00};

        for (int g = 0; g < NL; g++) begin
            for (int a = 0; a < 32; a++) keyMem[g][a] = 8'h00;
            start[g] = 1'b0; stop[g] = 1'b0; ksReady[g] = 1'b1; sInitCnt[g] = 0;
        end
        keyMem[0][0] = 8'h4B; keyMem[0][1] = 8'h65; keyMem[0][2] = 8'h79;
        keyMem[1][0] = 8'h57; keyMem[1][1] = 8'h69; keyMem[1][2] = 8'h6B; keyMem[1][3] = 8'h69;
        keyMem[2][0] = 8'h53; keyMem[2][1] = 8'h65; keyMem[2][2] = 8'h63;
        keyMem[2][3] = 8'h72; keyMem[2][4] = 8'h65; keyMem[2][5] = 8'h74;

        for (int v = 0; v < 3; v++) begin
            for (int n = 0; n < 10; n++) expStream[vecs[v].lane][n] = vecs[v].expBytes[n];
        end
`ifdef RC4_DROP256_EN
        for (int g = 0; g < NL; g++) buildRef(g, 256);
`endif

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy[0], 0);
        checkOutput("reset ks_valid", ksValid[0], 0);
        checkOutput("reset ks_data", ksData[0], 0);
        checkOutput("reset s_init", sInit[0], 0);
        checkOutput("reset wen_2", wen2[0], 0);
        checkOutput("reset wen_3", wen3[0], 0);
        checkOutput("reset key_idx", keyIdx[0], 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven keystream vectors, one lane per key length
        for (int v = 0; v < 3; v++) begin
            base = sInitCnt[vecs[v].lane];
            applyStimulus(vecs[v].lane);
            checkStream(vecs[v].lane, vecs[v].nBytes, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d s_init pulses", v), sInitCnt[vecs[v].lane] - base, 1);
            applyStop(vecs[v].lane);
            checkOutput($sformatf("vec%0d busy after stop", v), busy[vecs[v].lane], 0);
            checkOutput($sformatf("vec%0d valid after stop", v), ksValid[vecs[v].lane], 0);
        end

        // Back-pressure: first byte held while ready is low, next byte 4 cycles after ready rises
        ksReady[0] = 1'b0;
        applyStimulus(0);
        getByte(0, 1500, b, w1, ok);
        checkOutput("stall first byte", ok ? int'(b) : -1, expStream[0][0]);
        stableCnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ksValid[0] && ksData[0] == expStream[0][0]) stableCnt++;
        end
        checkOutput("stall held cycles", stableCnt, 20);
        @(posedge clk);
        #1;
        ksReady[0] = 1'b1;
        getByte(0, 20, b, w1, ok);
        checkOutput("stall handshake byte", ok ? int'(b) : -1, expStream[0][0]);
        getByte(0, 20, b, w2, ok);
        checkOutput("stall second byte", ok ? int'(b) : -1, expStream[0][1]);
        checkOutput("ready-rise to valid cycles", w1 + w2 - 1, 4);
        applyStop(0);

        // Stop during KSA_B with i = 100, then a clean restart
        applyStimulus(0);
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < 400) begin
            @(negedge clk);
            if (wen2[0] && waddr2[0] == 8'd100) found = 1'b1;
            else cnt++;
        end
        checkOutput("found KSA_A i=100", found, 1);
        @(negedge clk);
        checkOutput("in KSA_B before stop", wen3[0], 1);
        stop[0] = 1'b1;
        @(posedge clk);
        #1;
        stop[0] = 1'b0;
        checkOutput("stop busy", busy[0], 0);
        checkOutput("stop wen_3", wen3[0], 0);
        applyStimulus(0);
        checkStream(0, 10, "after stop");
        applyStop(0);

        // Asynchronous reset in the middle of keystream output, then restart
        applyStimulus(0);
        checkStream(0, 3, "pre reset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midreset ks_data", ksData[0], 0);
        checkOutput("midreset ks_valid", ksValid[0], 0);
        checkOutput("midreset busy", busy[0], 0);
        checkOutput("midreset wen_2", wen2[0], 0);
        checkOutput("midreset wen_3", wen3[0], 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0);
        checkStream(0, 4, "post reset");
        applyStop(0);

        checkOutput("wen_2/wen_3 overlap cycles", bothWen, 0);
        checkOutput("writes in quiet states", wenWhenQuiet, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
